// File: rtl/vscale_htif_pcr_arbiter_pkg.sv
// Shared constants and types for the HTIF PCR port arbiter.
//   HTIF_PCR_WIDTH : data width of the HTIF PCR port
//   CSR_ADDR_WIDTH : CSR address width
//   pcr_arb_state_e: arbiter FSM state encodings (2 bits)
package vscale_htif_pcr_arbiter_pkg;

    localparam int HTIF_PCR_WIDTH = 64;
    localparam int CSR_ADDR_WIDTH = 12;

    typedef enum logic [1:0] {
        PCR_ARB_IDLE = 2'b00,
        PCR_ARB_REQ  = 2'b01,
        PCR_ARB_RESP = 2'b10,
        PCR_ARB_ERR  = 2'b11
    } pcr_arb_state_e;

endpackage

// File: rtl/vscale_rr_picker.sv
// Combinational round-robin picker.
// Selects the first asserted bit of req, searching upward from ptr and
// wrapping modulo N.
//   req       : request vector
//   ptr       : highest-priority index this round
//   grant     : one-hot grant (all zero when nothing is requested)
//   grant_idx : binary index of the granted bit
//   any_valid : at least one request is asserted
module vscale_rr_picker #(
    parameter int unsigned N = 2,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_valid
);

    int unsigned idx;

    // Walk offsets from farthest to nearest so the nearest match wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
                any_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vscale_htif_pcr_arbiter.sv
// Shares the vscale HTIF PCR port between N_REQ host-side requesters.
// Round-robin grant, one transaction in flight, response routed back to the
// owner. A watchdog aborts a response that does not arrive within
// TIMEOUT_CYCLES cycles and returns an error response instead.
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   up_req_*              : per-requester request channel (flattened addr/data)
//   up_resp_*             : one-hot response valid, shared data and error flag
//   pcr_req_*, pcr_resp_* : core HTIF PCR port
//   timeout_sticky        : set on any watchdog abort, cleared only by reset
module vscale_htif_pcr_arbiter
    import vscale_htif_pcr_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [N_REQ-1:0]                   up_req_valid,
    output logic [N_REQ-1:0]                   up_req_ready,
    input  logic [N_REQ-1:0]                   up_req_rw,
    input  logic [N_REQ*CSR_ADDR_WIDTH-1:0]    up_req_addr,
    input  logic [N_REQ*HTIF_PCR_WIDTH-1:0]    up_req_data,
    output logic [N_REQ-1:0]                   up_resp_valid,
    input  logic [N_REQ-1:0]                   up_resp_ready,
    output logic [HTIF_PCR_WIDTH-1:0]          up_resp_data,
    output logic                               up_resp_err,
    output logic                               pcr_req_valid,
    input  logic                               pcr_req_ready,
    output logic                               pcr_req_rw,
    output logic [CSR_ADDR_WIDTH-1:0]          pcr_req_addr,
    output logic [HTIF_PCR_WIDTH-1:0]          pcr_req_data,
    input  logic                               pcr_resp_valid,
    output logic                               pcr_resp_ready,
    input  logic [HTIF_PCR_WIDTH-1:0]          pcr_resp_data,
    output logic                               timeout_sticky
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    pcr_arb_state_e            state_q, state_d;
    logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]          owner_q, owner_d;
    logic                      rw_q, rw_d;
    logic [CSR_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [HTIF_PCR_WIDTH-1:0] data_q, data_d;
    logic [WD_W-1:0]           wd_cnt_q, wd_cnt_d;
    logic                      sticky_q, sticky_d;

    logic [N_REQ-1:0]          pick_grant;
    logic [IDX_W-1:0]          pick_idx;
    logic                      pick_any;
    logic [IDX_W-1:0]          next_ptr;

    vscale_rr_picker #(
        .N (N_REQ)
    ) u_picker (
        .req       (up_req_valid),
        .ptr       (rr_ptr_q),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any_valid (pick_any)
    );

    assign next_ptr = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    assign pcr_req_rw     = rw_q;
    assign pcr_req_addr   = addr_q;
    assign pcr_req_data   = data_q;
    assign timeout_sticky = sticky_q;

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        owner_d        = owner_q;
        rw_d           = rw_q;
        addr_d         = addr_q;
        data_d         = data_q;
        wd_cnt_d       = wd_cnt_q;
        sticky_d       = sticky_q;
        up_req_ready   = '0;
        up_resp_valid  = '0;
        up_resp_data   = '0;
        up_resp_err    = 1'b0;
        pcr_req_valid  = 1'b0;
        pcr_resp_ready = 1'b0;

        unique case (state_q)
            PCR_ARB_IDLE: begin
                // Ready is the grant itself, so any valid request handshakes.
                up_req_ready = pick_grant;
                if (pick_any) begin
                    rw_d    = up_req_rw[pick_idx];
                    addr_d  = up_req_addr[pick_idx*CSR_ADDR_WIDTH +: CSR_ADDR_WIDTH];
                    data_d  = up_req_data[pick_idx*HTIF_PCR_WIDTH +: HTIF_PCR_WIDTH];
                    owner_d = pick_idx;
                    state_d = PCR_ARB_REQ;
                end
            end
            PCR_ARB_REQ: begin
                pcr_req_valid = 1'b1;
                if (pcr_req_ready) begin
                    state_d  = PCR_ARB_RESP;
                    wd_cnt_d = '0;
                end
            end
            PCR_ARB_RESP: begin
                up_resp_valid[owner_q] = pcr_resp_valid;
                up_resp_data           = pcr_resp_data;
                pcr_resp_ready         = up_resp_ready[owner_q];
                if (pcr_resp_valid) begin
                    // Owner backpressure holds the watchdog still.
                    if (up_resp_ready[owner_q]) begin
                        state_d  = PCR_ARB_IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end else if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d  = PCR_ARB_ERR;
                    sticky_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
            PCR_ARB_ERR: begin
                // A late core response is not consumed here; it lands in the
                // next RESP phase, so TIMEOUT_CYCLES must exceed core latency.
                up_resp_valid[owner_q] = 1'b1;
                up_resp_err            = 1'b1;
                if (up_resp_ready[owner_q]) begin
                    state_d  = PCR_ARB_IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = PCR_ARB_IDLE;
        endcase

        // Reset is synchronous, so mask handshakes while it is held.
        if (!reset) begin
            up_req_ready   = '0;
            up_resp_valid  = '0;
            up_resp_err    = 1'b0;
            pcr_req_valid  = 1'b0;
            pcr_resp_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= PCR_ARB_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            wd_cnt_q <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wd_cnt_q <= wd_cnt_d;
            sticky_q <= sticky_d;
        end
    end

endmodule

// File: tb/tb_vscale_htif_pcr_arbiter.sv
// Directed bench for vscale_htif_pcr_arbiter with two requesters and a short
// watchdog. The core side is driven directly by the stimulus sequence.
module tb_vscale_htif_pcr_arbiter;
    import vscale_htif_pcr_arbiter_pkg::*;

    localparam int unsigned NR = 2;
    localparam int unsigned TO = 8;

    logic                        clk = 1'b0;
    logic                        reset;
    logic [NR-1:0]               up_req_valid;
    logic [NR-1:0]               up_req_ready;
    logic [NR-1:0]               up_req_rw;
    logic [NR*CSR_ADDR_WIDTH-1:0] up_req_addr;
    logic [NR*HTIF_PCR_WIDTH-1:0] up_req_data;
    logic [NR-1:0]               up_resp_valid;
    logic [NR-1:0]               up_resp_ready;
    logic [HTIF_PCR_WIDTH-1:0]   up_resp_data;
    logic                        up_resp_err;
    logic                        pcr_req_valid;
    logic                        pcr_req_ready;
    logic                        pcr_req_rw;
    logic [CSR_ADDR_WIDTH-1:0]   pcr_req_addr;
    logic [HTIF_PCR_WIDTH-1:0]   pcr_req_data;
    logic                        pcr_resp_valid;
    logic                        pcr_resp_ready;
    logic [HTIF_PCR_WIDTH-1:0]   pcr_resp_data;
    logic                        timeout_sticky;

    int n_total = 0;
    int n_bad   = 0;
    int exp_ptr;

    always #5 clk = ~clk;

    vscale_htif_pcr_arbiter #(
        .N_REQ          (NR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .up_req_valid   (up_req_valid),
        .up_req_ready   (up_req_ready),
        .up_req_rw      (up_req_rw),
        .up_req_addr    (up_req_addr),
        .up_req_data    (up_req_data),
        .up_resp_valid  (up_resp_valid),
        .up_resp_ready  (up_resp_ready),
        .up_resp_data   (up_resp_data),
        .up_resp_err    (up_resp_err),
        .pcr_req_valid  (pcr_req_valid),
        .pcr_req_ready  (pcr_req_ready),
        .pcr_req_rw     (pcr_req_rw),
        .pcr_req_addr   (pcr_req_addr),
        .pcr_req_data   (pcr_req_data),
        .pcr_resp_valid (pcr_resp_valid),
        .pcr_resp_ready (pcr_resp_ready),
        .pcr_resp_data  (pcr_resp_data),
        .timeout_sticky (timeout_sticky)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 2ns after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset          = 1'b0;
        up_req_valid   = '0;
        up_req_rw      = '0;
        up_req_addr    = '0;
        up_req_data    = '0;
        up_resp_ready  = '0;
        pcr_req_ready  = 1'b0;
        pcr_resp_valid = 1'b0;
        pcr_resp_data  = '0;
        tick();
        tick();

        // Outputs stay quiet while reset is held, even with requests pending.
        up_req_valid = 2'b11;
        settle();
        check_eq("rst_req_ready", up_req_ready, 0);
        check_eq("rst_pcr_req_valid", pcr_req_valid, 0);
        check_eq("rst_resp_valid", up_resp_valid, 0);
        check_eq("rst_pcr_resp_ready", pcr_resp_ready, 0);
        check_eq("rst_sticky", timeout_sticky, 0);
        up_req_valid = '0;
        reset = 1'b1;
        tick();

        // Single read of tohost from requester 0, core answers 3 cycles later.
        up_req_valid = 2'b01;
        up_req_addr[11:0] = 12'h780;
        settle();
        check_eq("rd_req_ready", up_req_ready, 2'b01);
        tick();
        up_req_valid = '0;
        settle();
        check_eq("rd_pcr_req_valid", pcr_req_valid, 1);
        check_eq("rd_pcr_addr", pcr_req_addr, 12'h780);
        check_eq("rd_pcr_rw", pcr_req_rw, 0);
        pcr_req_ready = 1'b1;
        tick();
        pcr_req_ready = 1'b0;
        settle();
        check_eq("rd_req_dropped", pcr_req_valid, 0);
        check_eq("rd_no_early_resp", up_resp_valid, 0);
        tick();
        tick();
        pcr_resp_valid = 1'b1;
        pcr_resp_data  = 64'd144;
        up_resp_ready  = 2'b01;
        settle();
        check_eq("rd_resp_valid", up_resp_valid, 2'b01);
        check_eq("rd_resp_data", up_resp_data, 64'd144);
        check_eq("rd_resp_err", up_resp_err, 0);
        check_eq("rd_pcr_resp_ready", pcr_resp_ready, 1);
        tick();
        pcr_resp_valid = 1'b0;

        // Contention: both requesters always valid; pointer now at 1.
        exp_ptr = 1;
        up_req_addr = {12'h200, 12'h100};
        up_req_data = {64'hBBBB_0001, 64'hAAAA_0000};
        up_resp_ready = 2'b11;
        for (int t = 0; t < 6; t++) begin
            up_req_valid = 2'b11;
            settle();
            check_eq("rr_grant", up_req_ready, 2'b01 << exp_ptr);
            tick();
            settle();
            check_eq("rr_no_regrant", up_req_ready, 0);
            check_eq("rr_pcr_addr", pcr_req_addr, (exp_ptr == 1) ? 12'h200 : 12'h100);
            pcr_req_ready = 1'b1;
            tick();
            pcr_req_ready  = 1'b0;
            pcr_resp_valid = 1'b1;
            pcr_resp_data  = 64'h55 + 64'(t);
            settle();
            check_eq("rr_resp_route", up_resp_valid, 2'b01 << exp_ptr);
            check_eq("rr_resp_data", up_resp_data, 64'h55 + 64'(t));
            tick();
            pcr_resp_valid = 1'b0;
            exp_ptr = 1 - exp_ptr;
        end
        up_resp_ready = '0;

        // Core backpressure on the request; requester inputs churn meanwhile.
        up_req_valid = 2'b01;
        up_req_rw    = 2'b01;
        up_req_addr  = {12'h333, 12'h7C0};
        up_req_data  = {64'h1111, 64'hDEAD_BEEF_1234_5678};
        settle();
        check_eq("bp_grant_wrap", up_req_ready, 2'b01);
        tick();
        for (int i = 0; i < 5; i++) begin
            up_req_valid = (i % 2 == 0) ? 2'b10 : 2'b11;
            up_req_rw    = 2'(i);
            up_req_addr  = {12'(i + 12'h400), 12'(i)};
            up_req_data  = {64'(i * 7), 64'(i * 3)};
            settle();
            check_eq("bp_valid", pcr_req_valid, 1);
            check_eq("bp_addr", pcr_req_addr, 12'h7C0);
            check_eq("bp_data", pcr_req_data, 64'hDEAD_BEEF_1234_5678);
            check_eq("bp_rw", pcr_req_rw, 1);
            check_eq("bp_no_grant", up_req_ready, 0);
            tick();
        end
        up_req_valid  = '0;
        pcr_req_ready = 1'b1;
        tick();
        pcr_req_ready  = 1'b0;
        pcr_resp_valid = 1'b1;
        pcr_resp_data  = '0;
        up_resp_ready  = 2'b01;
        settle();
        check_eq("bp_resp_route", up_resp_valid, 2'b01);
        tick();
        pcr_resp_valid = 1'b0;

        // Response stall from requester 1 with the core response held.
        up_req_valid = 2'b10;
        settle();
        check_eq("st_grant", up_req_ready, 2'b10);
        tick();
        up_req_valid  = '0;
        pcr_req_ready = 1'b1;
        tick();
        pcr_req_ready  = 1'b0;
        pcr_resp_valid = 1'b1;
        pcr_resp_data  = 64'h1234;
        up_resp_ready  = 2'b01;
        for (int i = 0; i < 4; i++) begin
            settle();
            check_eq("st_valid", up_resp_valid, 2'b10);
            check_eq("st_pcr_ready", pcr_resp_ready, 0);
            check_eq("st_err", up_resp_err, 0);
            tick();
        end
        up_resp_ready = 2'b10;
        settle();
        check_eq("st_deliver_ready", pcr_resp_ready, 1);
        check_eq("st_deliver_data", up_resp_data, 64'h1234);
        check_eq("st_deliver_valid", up_resp_valid, 2'b10);
        tick();
        pcr_resp_valid = 1'b0;
        up_resp_ready  = '0;
        settle();
        check_eq("st_no_timeout", timeout_sticky, 0);

        // Watchdog: core never answers requester 0.
        up_req_valid = 2'b01;
        settle();
        check_eq("wd_grant", up_req_ready, 2'b01);
        tick();
        up_req_valid  = '0;
        pcr_req_ready = 1'b1;
        tick();
        pcr_req_ready = 1'b0;
        pcr_resp_data = 64'hFFFF;
        for (int i = 0; i < 7; i++) tick();
        settle();
        check_eq("wd_pre_valid", up_resp_valid, 0);
        check_eq("wd_pre_sticky", timeout_sticky, 0);
        tick();
        check_eq("wd_err_valid", up_resp_valid, 2'b01);
        check_eq("wd_err_flag", up_resp_err, 1);
        check_eq("wd_err_data", up_resp_data, 0);
        check_eq("wd_sticky", timeout_sticky, 1);
        check_eq("wd_pcr_ready", pcr_resp_ready, 0);
        tick();
        check_eq("wd_err_hold", up_resp_valid, 2'b01);
        up_resp_ready = 2'b01;
        tick();
        up_resp_ready = '0;
        settle();
        check_eq("wd_back_idle", up_resp_valid, 0);
        check_eq("wd_sticky_kept", timeout_sticky, 1);

        // Next request after the abort is serviced normally.
        up_req_valid = 2'b01;
        settle();
        check_eq("post_grant", up_req_ready, 2'b01);
        tick();
        up_req_valid  = '0;
        pcr_req_ready = 1'b1;
        tick();
        pcr_req_ready  = 1'b0;
        pcr_resp_valid = 1'b1;
        pcr_resp_data  = 64'h99;
        up_resp_ready  = 2'b01;
        settle();
        check_eq("post_valid", up_resp_valid, 2'b01);
        check_eq("post_err", up_resp_err, 0);
        check_eq("post_data", up_resp_data, 64'h99);

        // Reset while still in RESP: no handshake happens, then reset.
        pcr_resp_valid = 1'b0;
        up_resp_ready  = '0;
        reset = 1'b0;
        settle();
        check_eq("mr_pcr_ready_masked", pcr_resp_ready, 0);
        tick();
        reset = 1'b1;
        settle();
        check_eq("mr_sticky_clr", timeout_sticky, 0);
        check_eq("mr_req_valid", pcr_req_valid, 0);
        check_eq("mr_resp_valid", up_resp_valid, 0);
        up_req_valid = 2'b11;
        settle();
        check_eq("mr_ptr_zero", up_req_ready, 2'b01);
        up_req_valid = '0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
